// File: rtl/sw_pkg.sv
// Shared definitions for the switch egress link: frame layout helpers and
// the receive-port handshake states.
package sw_pkg;

  localparam logic SIDE_X = 1'b0;
  localparam logic SIDE_Y = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_t;

  // Frame layout is {src_side, src_port[1:0], payload[dw-1:0]}
  function automatic int FRAME_W(input int dw);
    return dw + 3;
  endfunction

  function automatic int SIDE_BIT(input int dw);
    return dw + 2;
  endfunction

  function automatic int PORT_MSB(input int dw);
    return dw + 1;
  endfunction

  function automatic int PORT_LSB(input int dw);
    return dw;
  endfunction

endpackage

// File: rtl/dev_rx_fifo.sv
// Show-ahead FIFO with wrap-bit pointers; the head word is visible whenever
// the FIFO is non-empty and reads as zero when it is empty.
module dev_rx_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic             full,
  output logic [DEPTH:0]   count
);

  logic [W-1:0] mem [2**DEPTH];
  logic [DEPTH:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[DEPTH] != rd_ptr[DEPTH]) &&
                   (wr_ptr[DEPTH-1:0] == rd_ptr[DEPTH-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rd_ptr[DEPTH-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers mask the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH-1:0]] <= din;
  end

endmodule

// File: rtl/dev_rx_port.sv
// Device-side receive endpoint of a switch egress link: synchronizes the
// request, runs the four-phase ack handshake and buffers frames for local logic.
module dev_rx_port
  import sw_pkg::*;
#(
  parameter int DW          = 4,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FRAME_W(DW)-1:0] dat_o,
  input  logic                  validrx,
  output logic                  ackrx,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DW-1:0]         rx_data,
  output logic                  rx_src_side,
  output logic [1:0]            rx_src_port,
  output logic [DEPTH:0]        rx_count,
  output logic                  proto_err,
  output rx_state_t             fsm_state
);

  // Handshake: the switch holds dat_o stable while validrx is high; ackrx
  // rises once the frame is stored and falls after validrx is withdrawn.
  // Local side: a frame leaves the FIFO on any edge with rx_valid && rx_ready.

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   vsync;
  rx_state_t              state_q, state_d;
  logic                   push, full, blocked_q;
  logic [FRAME_W(DW)-1:0] head;

  assign vsync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], validrx};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: if (vsync && !full) begin
        push    = 1'b1;
        state_d = ACK;
      end
      ACK: if (!vsync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ackrx     = (state_q == ACK);
  assign fsm_state = state_q;

  // A request seen while full that disappears before being accepted was withdrawn.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      blocked_q <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      blocked_q <= (state_q == IDLE) && vsync && full;
      if ((state_q == IDLE) && blocked_q && !vsync) proto_err <= 1'b1;
    end
  end

  dev_rx_fifo #(
    .W     (FRAME_W(DW)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (push),
    .din   (dat_o),
    .pop   (rx_ready),
    .dout  (head),
    .valid (rx_valid),
    .full  (full),
    .count (rx_count)
  );

  assign rx_data     = head[DW-1:0];
  assign rx_src_side = head[SIDE_BIT(DW)];
  assign rx_src_port = head[PORT_MSB(DW):PORT_LSB(DW)];

endmodule

// File: tb/tb_dev_rx_port.sv
// Directed bench for dev_rx_port: vector table for frame decode/order plus
// hand-written sequences for back-pressure, push/pop overlap, reset and proto_err.
module tb_dev_rx_port;
  import sw_pkg::*;

  localparam int DW    = 4;
  localparam int DEPTH = 2;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic [DW+2:0]  dat_o;
  logic           validrx;
  logic           ackrx;
  logic           rx_valid;
  logic           rx_ready;
  logic [DW-1:0]  rx_data;
  logic           rx_src_side;
  logic [1:0]     rx_src_port;
  logic [DEPTH:0] rx_count;
  logic           proto_err;
  rx_state_t      fsm_state;

  int checks = 0;
  int passes = 0;
  logic [DW+2:0] exp_q[$];

  dev_rx_port #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dat_o       (dat_o),
    .validrx     (validrx),
    .ackrx       (ackrx),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_src_side (rx_src_side),
    .rx_src_port (rx_src_port),
    .rx_count    (rx_count),
    .proto_err   (proto_err),
    .fsm_state   (fsm_state)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [DW+2:0] frame;
    logic [DW-1:0] exp_data;
    logic          exp_side;
    logic [1:0]    exp_port;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ack(input logic level, output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ackrx === level) begin
        n = i;
        break;
      end
    end
  endtask

  // Full four-phase handshake for one frame, with space assumed in the FIFO.
  task automatic send_frame(input logic [DW+2:0] f);
    int n;
    dat_o   = f;
    validrx = 1'b1;
    wait_ack(1'b1, n);
    chk("ack_rise_latency", n, 3);
    exp_q.push_back(f);
    validrx = 1'b0;
    wait_ack(1'b0, n);
    chk("ack_fall_latency", n, 3);
  endtask

  task automatic pop_one();
    logic [DW+2:0] e;
    chk("pop_valid", rx_valid, 1'b1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("pop_data", rx_data, e[DW-1:0]);
      chk("pop_side", rx_src_side, e[DW+2]);
      chk("pop_port", rx_src_port, e[DW+1:DW]);
    end
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_i    = 1'b0;
    validrx  = 1'b0;
    rx_ready = 1'b0;
    dat_o    = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_ackrx", ackrx, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_count", rx_count, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_rx_data", {rx_src_side, rx_src_port, rx_data}, 0);
    chk("rst_state", fsm_state, IDLE);
    rst_i = 1'b1;
    tick();

    // Pop on empty is ignored
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("empty_pop_count", rx_count, 0);
    chk("empty_pop_valid", rx_valid, 0);

    // Frame decode and ordering table
    vecs[0] = '{7'b1_10_1011, 4'hB, 1'b1, 2'd2};
    vecs[1] = '{7'b0_00_0001, 4'h1, 1'b0, 2'd0};
    vecs[2] = '{7'b1_11_0010, 4'h2, 1'b1, 2'd3};
    vecs[3] = '{7'b0_10_0011, 4'h3, 1'b0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].frame);
      chk("tbl_count", rx_count, i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      chk("tbl_valid", rx_valid, 1'b1);
      chk("tbl_data", rx_data, vecs[i].exp_data);
      chk("tbl_side", rx_src_side, vecs[i].exp_side);
      chk("tbl_port", rx_src_port, vecs[i].exp_port);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
    end
    exp_q.delete();
    chk("tbl_drained", rx_count, 0);

    // Fill with rx_ready low; fifth frame must be held off
    for (int i = 0; i < 4; i++) send_frame(7'(8'h40 + i * 5));
    chk("fill_count", rx_count, 4);
    dat_o   = 7'b1_01_1110;
    validrx = 1'b1;
    repeat (6) tick();
    chk("full_no_ack", ackrx, 0);
    chk("full_count", rx_count, 4);
    chk("full_state", fsm_state, IDLE);
    pop_one();
    chk("after_pop_count", rx_count, 3);
    tick();
    chk("full_late_ack", ackrx, 1);
    chk("refill_count", rx_count, 4);
    exp_q.push_back(7'b1_01_1110);
    validrx = 1'b0;
    wait_ack(1'b0, n);
    chk("full_ack_fall", n, 3);
    chk("no_proto_err", proto_err, 0);
    while (exp_q.size() > 0) pop_one();
    chk("fill_drained", rx_count, 0);

    // Push and pop on the same edge at count 2
    send_frame(7'b0_01_0101);
    send_frame(7'b1_00_0110);
    dat_o   = 7'b0_11_0111;
    validrx = 1'b1;
    tick();
    tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(7'b0_11_0111);
    chk("overlap_ack", ackrx, 1);
    chk("overlap_count", rx_count, 2);
    chk("overlap_head", {rx_src_side, rx_src_port, rx_data}, 7'b1_00_0110);
    validrx = 1'b0;
    wait_ack(1'b0, n);
    chk("overlap_ack_fall", n, 3);
    while (exp_q.size() > 0) pop_one();

    // Asynchronous reset while acknowledging
    dat_o   = 7'b1_11_1001;
    validrx = 1'b1;
    wait_ack(1'b1, n);
    chk("pre_rst_ack", n, 3);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_ackrx", ackrx, 0);
    chk("async_rst_valid", rx_valid, 0);
    chk("async_rst_count", rx_count, 0);
    chk("async_rst_state", fsm_state, IDLE);
    validrx = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    send_frame(7'b0_01_1100);
    pop_one();

    // Request withdrawn while blocked by a full FIFO
    for (int i = 0; i < 4; i++) send_frame(7'(8'h10 + i));
    dat_o   = 7'b1_10_0000;
    validrx = 1'b1;
    repeat (5) tick();
    chk("blocked_no_ack", ackrx, 0);
    chk("blocked_no_err", proto_err, 0);
    validrx = 1'b0;
    repeat (4) tick();
    chk("withdraw_err", proto_err, 1);
    while (exp_q.size() > 0) pop_one();
    chk("err_sticky", proto_err, 1);
    chk("err_drained", rx_count, 0);
    rst_i = 1'b0;
    #1;
    chk("err_reset", proto_err, 0);
    rst_i = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
